amdc_spi_adc_master: RTL

AMDC_SPI_ADC_MASTER -- requirements
Module: amdc_spi_adc_master

---
 rtl/amdc_spi_pkg.sv | 17 +
 rtl/amdc_spi_rx_shifter.sv | 21 ++
 rtl/amdc_spi_adc_master.sv | 124 ++++++++++++
 3 files changed

// File: rtl/amdc_spi_pkg.sv
// Shared types and default parameters for the SPI ADC master.
// Optional sample counter in the top is enabled by AMDC_SPI_SAMPLE_CNT_EN.
package amdc_spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CNV  = 2'd1;
  localparam state_t S_RX   = 2'd2;
  localparam state_t S_HOLD = 2'd3;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_DATA_W  = 18;
  localparam int DEF_CLK_DIV = 16;
  localparam int DEF_TQUIET  = 54;

endpackage

// File: rtl/amdc_spi_rx_shifter.sv
// Per-channel MSB-first serial-in shift register.
// One instance per ADC channel.
module amdc_spi_rx_shifter #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/amdc_spi_adc_master.sv
// Multi-channel SPI ADC master: CNV strobe, shared SCLK, parallel MISO capture.
// Define AMDC_SPI_SAMPLE_CNT_EN to add the 16-bit sample_count output.
module amdc_spi_adc_master
  import amdc_spi_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int TQUIET1_CYC = DEF_TQUIET,
  parameter int TQUIET2_CYC = DEF_TQUIET
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        miso,
  output logic                     sclk,
  output logic                     cnv,
  output logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     sample_valid,
`ifdef AMDC_SPI_SAMPLE_CNT_EN
  output logic [15:0]              sample_count,
`endif
  output logic                     busy
);

  localparam int QMAX = (TQUIET1_CYC > TQUIET2_CYC) ? TQUIET1_CYC : TQUIET2_CYC;
  localparam int QW   = $clog2(QMAX + 1);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATA_W);

  state_t                     state;
  state_t                     state_nx;
  logic [QW-1:0]              q_cnt;
  logic [DW-1:0]              div_cnt;
  logic [DW-1:0]              div_nx;
  logic [BW-1:0]              bit_cnt;
  logic [NUM_CH*DATA_W-1:0]   shreg;
  logic                       shift_en;
  logic                       div_last;
  logic                       rx_done;
  logic                       q1_done;
  logic                       q2_done;

  assign shift_en = (state == S_RX) && (div_cnt == '0);
  assign div_last = div_cnt == DW'(CLK_DIV - 1);
  assign div_nx   = div_last ? '0 : div_cnt + 1'b1;
  assign rx_done  = div_last && (bit_cnt == BW'(DATA_W - 1));
  assign q1_done  = q_cnt == QW'(TQUIET1_CYC - 1);
  assign q2_done  = q_cnt == QW'(TQUIET2_CYC - 1);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (enable && (mode || start)) state_nx = S_CNV;
      S_CNV:  if (q1_done) state_nx = S_RX;
      S_RX:   if (rx_done) state_nx = S_HOLD;
      S_HOLD: if (q2_done) state_nx = (enable && mode) ? S_CNV : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      q_cnt        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sclk         <= 1'b0;
      cnv          <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      state        <= state_nx;
      cnv          <= state_nx == S_CNV;
      busy         <= state_nx != S_IDLE;
      sample_valid <= 1'b0;
      if (state_nx != state) begin
        q_cnt <= '0;
      end else if (state == S_CNV || state == S_HOLD) begin
        q_cnt <= q_cnt + 1'b1;
      end
      if (state == S_RX && !rx_done) begin
        div_cnt <= div_nx;
        bit_cnt <= div_last ? bit_cnt + 1'b1 : bit_cnt;
        sclk    <= div_nx >= DW'(CLK_DIV / 2);
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end
      if (state == S_RX && rx_done) begin
        sample_data  <= shreg;
        sample_valid <= 1'b1;
      end
    end
  end

`ifdef AMDC_SPI_SAMPLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
    end else if (state == S_RX && rx_done) begin
      sample_count <= sample_count + 1'b1;
    end
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    amdc_spi_rx_shifter #(
      .W(DATA_W)
    ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_en(shift_en),
      .din     (miso[g]),
      .q       (shreg[g*DATA_W +: DATA_W])
    );
  end

endmodule
